i2c_codec_target: RTL
=====================

# i2c_codec_target

I2C write-only target that answers the codec control transactions our audio initializer issues (device byte 0x34, then a 7-bit register address plus 9-bit data), ACKs them, and stores the data in a local register file. It sits on the I2C_SCLK/I2C_SDAT pair opposite the initializer. It serves as the on-chip codec-register model for loopback bring-up and as the simulation responder for the initializer. All logic runs on the 50 MHz system clock, which oversamples the ~10 kHz bus.

## Interface
- DEV_ADDR, 7'h1A, 7-bit target address; the device byte is {DEV_ADDR, R/W} = 0x34 for write.
- NUM_REGS, 10, number of stored 9-bit registers (addresses 0..NUM_REGS-1).
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA inputs.

Ports:
- Clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- I2C_SCLK  in  1  bus clock from the initiator; open-drain, may be high or low asynchronously.
- I2C_SDAT  inout  1  bus data; the block only drives 0 or Z.
- rd_addr  in  4  register-file read address.
- rd_data  out  9  registered read data for rd_addr; 0 when rd_addr ≥ NUM_REGS.
- wr_strobe  out  1  one-Clk pulse on each committed register write (including a 0x0F reset).
- wr_addr  out  7  address of the last committed write.
- wr_data  out  9  data of the last committed write.
- busy  out  1  high from a START addressed to DEV_ADDR until STOP or abort.
- invalid_wr  out  1  sticky; set on an ACKed write to an address in NUM_REGS..14; cleared only by reset.

## Operation
- Input conditioning: SCL and SDA each pass through SYNC_STAGES flops, plus one delay flop for edge detection. Internal events:
  - scl_rise, scl_fall.
  - start: SDA falls while SCL is high.
  - stop: SDA rises while SCL is high.
- Data is sampled on scl_rise, MSB first. SDA is driven only on scl_fall.
- States: IDLE, DEV, DEV_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
  - IDLE: wait for start, then go to DEV with the bit counter at 0.
  - DEV: shift 8 bits. On the scl_fall after bit 8:
    - byte equals {DEV_ADDR, 0}: drive SDA low, enter DEV_ACK, raise busy.
    - otherwise, including R/W = 1: leave SDA released, enter IGNORE.
  - DEV_ACK, ACK1: hold SDA low until the next scl_fall, then release it and enter the next byte state.
  - BYTE1: shift 8 bits = {reg_addr[6:0], data[8]}. On the scl_fall after bit 8, drive ACK and enter ACK1.
  - BYTE2: shift 8 bits = data[7:0]. On the scl_fall after bit 8, drive ACK, enter ACK2, and commit the write.
  - ACK2: release SDA on the next scl_fall, then enter IGNORE. Any further bytes get no ACK.
  - IGNORE: SDA stays released; wait for start or stop.
- Commit rules, applied on the same Clk as entry to ACK2:
  - reg_addr < NUM_REGS: write the register, update wr_addr/wr_data, pulse wr_strobe.
  - reg_addr = 7'h0F: clear all registers to 0 (the codec reset register), update wr_addr/wr_data, pulse wr_strobe.
  - NUM_REGS ≤ reg_addr ≤ 14: ACK anyway, no store, no strobe, set invalid_wr.
  - reg_addr > 15: ACK, no store, no strobe, invalid_wr unchanged.
- stop in any state: go to IDLE, release SDA, clear busy. A transfer without a completed BYTE2 commits nothing.
- start in any state (repeated START): go to DEV, counter 0, release SDA, clear busy.
- start/stop take priority over scl edges detected in the same Clk.

## Timing
- Reset values:
  - I2C_SDAT = Z.
  - rd_data = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, busy = 0, invalid_wr = 0.
  - All registers = 0; state = IDLE.
- A reset asserted mid-transfer releases SDA on the next Clk and drops the transfer.
- Event latency: bus pin change to internal event = SYNC_STAGES+1 Clk.
- ACK drive: SDA goes low ≤ SYNC_STAGES+2 Clk after the SCL falling pin edge, and is held through the following SCL high phase.
- rd_data is valid 1 Clk after rd_addr changes. A write to the addressed register appears on rd_data on the Clk after wr_strobe.
- wr_strobe lasts exactly 1 Clk per committed transaction.
- Requirement: Clk ≥ 20× SCL frequency, with SCL high/low phases each > SYNC_STAGES+3 Clk.

## Test plan
- Write 0x34, 0x04, 0x14 (reg 2, data 20) then STOP -> three ACKs observed, one wr_strobe with wr_addr = 2 and wr_data = 9'd20, rd_addr = 2 reads 20, busy low after STOP.
- Run the 8-register initializer sequence (regs 1..8 with 119, 119, 20, 6, 0, 77, 0, 1, byte1 = {addr, d8}) -> every register reads back its value, 8 strobes, invalid_wr = 0.
- Device byte 0x36, then byte 0x35 (read) -> no ACK on either, SDA never driven low, no strobe, busy stays 0.
- Write to reg 12 -> ACKed, invalid_wr = 1, no strobe. Next, write reg 0x0F with data 0 -> strobe with wr_addr = 0x0F, all registers read 0.
- STOP after BYTE1, and separately a repeated START mid-BYTE2 followed by a full write to reg 5 data 0x1FF -> the aborted transfers commit nothing; reg 5 = 0x1FF with exactly one strobe.
- Assert reset while SDA is held low in ACK1 -> SDA released the next Clk, all outputs at reset values, and the next complete transaction succeeds.

Source files
------------

// File: rtl/i2c_codec_target.sv
// i2c_codec_target
//   Write-only I2C target that answers the codec control writes issued by
//   the audio initializer. Each write is the device byte, then
//   {reg_addr[6:0], data[8]}, then data[7:0]. The target ACKs the write and
//   stores the data in a small local register file. Everything runs on Clk,
//   which oversamples the slow bus.
//
// Handshake/valid semantics: wr_strobe is a single-Clk qualifier for
//   wr_addr/wr_data. There is no back-pressure. rd_data is a registered view
//   of rd_addr with one Clk of latency.
//
// Ports
//   Clk        system clock (single domain)
//   reset      synchronous, active-high reset
//   I2C_SCLK   bus clock from the initiator (asynchronous to Clk)
//   I2C_SDAT   open-drain bus data; this block only drives 0 or Z
//   rd_addr    register-file read address
//   rd_data    registered read data; 0 for addresses >= NUM_REGS
//   wr_strobe  one-Clk pulse per committed register write
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   busy       high from an addressed START until STOP or abort
//   invalid_wr sticky flag for ACKed writes to addresses NUM_REGS..14
//   dbg_state  current protocol FSM state, for debug and checkers
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         NUM_REGS    = 10,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic       invalid_wr,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_IGNORE
    } state_t;

    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);
    localparam logic [6:0] RESET_REG  = 7'h0F;
    localparam logic [6:0] LAST_RSVD  = 7'd14;

    // Input conditioning
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_dly_q, sda_dly_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    // Protocol FSM
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte1_q, byte1_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       commit;

    // Register file and outputs
    logic [8:0] regs_q [NUM_REGS];
    logic [8:0] rd_mux;
    logic [8:0] rd_data_q;
    logic       wr_strobe_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;
    logic       invalid_q;
    logic [6:0] cmt_addr;
    logic [8:0] cmt_data;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise = scl_s & ~scl_dly_q;
    assign scl_fall = ~scl_s & scl_dly_q;
    // SCL must be high on both samples so an SCL edge coinciding with an SDA
    // edge is never mistaken for START/STOP.
    assign start_ev = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_ev  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

    always_ff @(posedge Clk) begin
        if (reset) begin
            // Bus idles high, so the sync flops start high to avoid false events.
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            byte1_q    <= 8'd0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], I2C_SDAT};
            scl_dly_q  <= scl_s;
            sda_dly_q  <= sda_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            byte1_q    <= byte1_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        byte1_d  = byte1_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        commit   = 1'b0;
        if (stop_ev) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_ev) begin
            state_d  = S_DEV;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_DEV, S_BYTE1, S_BYTE2: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        // Eighth bit is complete; the ACK slot starts now.
                        cnt_d = 4'd0;
                        if (state_q == S_DEV) begin
                            if (shift_q == {DEV_ADDR, 1'b0}) begin
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                state_d  = S_DEV_ACK;
                            end else begin
                                state_d  = S_IGNORE;
                            end
                        end else if (state_q == S_BYTE1) begin
                            byte1_d  = shift_q;
                            sda_oe_d = 1'b1;
                            state_d  = S_ACK1;
                        end else begin
                            sda_oe_d = 1'b1;
                            state_d  = S_ACK2;
                            commit   = 1'b1;
                        end
                    end
                end
                S_DEV_ACK: if (scl_fall) begin sda_oe_d = 1'b0; state_d = S_BYTE1; end
                S_ACK1:    if (scl_fall) begin sda_oe_d = 1'b0; state_d = S_BYTE2; end
                S_ACK2:    if (scl_fall) begin sda_oe_d = 1'b0; state_d = S_IGNORE; end
                default: ;
            endcase
        end
    end

    // At commit time shift_q still holds the second byte.
    assign cmt_addr = byte1_q[7:1];
    assign cmt_data = {byte1_q[0], shift_q};

    always_comb begin
        rd_mux = 9'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 4'(i)) rd_mux = regs_q[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 9'd0;
            rd_data_q   <= 9'd0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 9'd0;
            invalid_q   <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            rd_data_q   <= rd_mux;
            if (commit) begin
                if (cmt_addr < NUM_REGS_A) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (cmt_addr == 7'(i)) regs_q[i] <= cmt_data;
                    end
                    wr_strobe_q <= 1'b1;
                    wr_addr_q   <= cmt_addr;
                    wr_data_q   <= cmt_data;
                end else if (cmt_addr == RESET_REG) begin
                    // Codec reset register: clears the whole file.
                    for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 9'd0;
                    wr_strobe_q <= 1'b1;
                    wr_addr_q   <= cmt_addr;
                    wr_data_q   <= cmt_data;
                end else if (cmt_addr <= LAST_RSVD) begin
                    invalid_q <= 1'b1;
                end
                // Addresses above 15 are ACKed and silently dropped.
            end
        end
    end

    assign I2C_SDAT   = sda_oe_q ? 1'b0 : 1'bz;
    assign rd_data    = rd_data_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign invalid_wr = invalid_q;
    assign dbg_state  = state_q;

endmodule
